// File: rtl/replay_schedule_if.sv
// Bundle carrying the session requests and every schedule output of the replay
// sequencer.
//   start, stop         : session requests (master -> slave)
//   start_count         : session running (FILL/RUN/DRAIN)
//   cycle_counter       : position within the gamma cycle, 0..G-1
//   half_cycle_counter  : position within the half cycle, 0..G/2-1
//   wr_idx              : demux write index, 2*half_cycle_counter
//   buf_sel             : ping-pong buffer select
//   network_buf_sel     : 1 = first half (network 0), 0 = second half
//   gamma_start         : one-clock pulse at cycle_counter==0 in a session
//   out_valid           : demux outputs hold replayed data
//   busy                : sequencer not idle
// The slave modport is the sequencer; the master modport is its user.
interface replay_schedule_if #(
  parameter int GAMMA_CYCLE_LENGTH = 18
) ();
  localparam int CW  = $clog2(GAMMA_CYCLE_LENGTH);
  localparam int HCW = $clog2(GAMMA_CYCLE_LENGTH / 2);

  logic           start;
  logic           stop;
  logic           start_count;
  logic [CW-1:0]  cycle_counter;
  logic [HCW-1:0] half_cycle_counter;
  logic [CW-1:0]  wr_idx;
  logic           buf_sel;
  logic           network_buf_sel;
  logic           gamma_start;
  logic           out_valid;
  logic           busy;

  modport master (
    output start, stop,
    input  start_count, cycle_counter, half_cycle_counter, wr_idx,
           buf_sel, network_buf_sel, gamma_start, out_valid, busy
  );

  modport slave (
    input  start, stop,
    output start_count, cycle_counter, half_cycle_counter, wr_idx,
           buf_sel, network_buf_sel, gamma_start, out_valid, busy
  );
endinterface

// File: rtl/replay_schedule_ctrl.sv
// Gamma-cycle sequencer for the time-multiplexed two-network column.
// Produces all timing/select signals consumed by the replay-buffer demux and
// the multiplexed column from one synchronous source. A session is a FILL
// gamma cycle, zero or more RUN gamma cycles and one DRAIN gamma cycle, with
// state changes only on gamma boundaries.
// Ports:
//   clk   : system clock, all logic on posedge
//   rstb  : synchronous active-low reset
//   bus   : replay_schedule_if slave (start/stop in, schedule outputs out)
// Every output is driven straight from a flop.
module replay_schedule_ctrl #(
  parameter int GAMMA_CYCLE_LENGTH = 18
) (
  input logic             clk,
  input logic             rstb,
  replay_schedule_if.slave bus
);
  localparam int CW  = $clog2(GAMMA_CYCLE_LENGTH);
  localparam int HCW = $clog2(GAMMA_CYCLE_LENGTH / 2);

  localparam logic [CW-1:0]  CNT_LAST  = CW'(GAMMA_CYCLE_LENGTH - 1);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(GAMMA_CYCLE_LENGTH / 2);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(GAMMA_CYCLE_LENGTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state_reg, state_next;
  logic           stop_pend_reg, stop_pend_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [HCW-1:0] half_reg, half_next;
  logic [CW-1:0]  wr_idx_reg, wr_idx_next;
  logic           buf_sel_reg, buf_sel_next;
  logic           net_sel_reg, net_sel_next;
  logic           gamma_start_reg, gamma_start_next;
  logic           out_valid_reg, out_valid_next;
  logic           busy_reg, busy_next;
  logic           wrap;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_reg       <= IDLE;
      stop_pend_reg   <= 1'b0;
      cnt_reg         <= '0;
      half_reg        <= '0;
      wr_idx_reg      <= '0;
      buf_sel_reg     <= 1'b0;
      net_sel_reg     <= 1'b0;
      gamma_start_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      stop_pend_reg   <= stop_pend_next;
      cnt_reg         <= cnt_next;
      half_reg        <= half_next;
      wr_idx_reg      <= wr_idx_next;
      buf_sel_reg     <= buf_sel_next;
      net_sel_reg     <= net_sel_next;
      gamma_start_reg <= gamma_start_next;
      out_valid_reg   <= out_valid_next;
      busy_reg        <= busy_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    stop_pend_next   = stop_pend_reg;
    cnt_next         = '0;
    half_next        = '0;
    wr_idx_next      = '0;
    buf_sel_next     = 1'b0;
    net_sel_next     = 1'b0;
    gamma_start_next = 1'b0;
    // Mirrors the demux's one-clock output register: data seen now was
    // replayed during the previous clock.
    out_valid_next   = (state_reg == RUN) || (state_reg == DRAIN);
    wrap             = (cnt_reg == CNT_LAST);

    if (state_reg == IDLE) begin
      // A stop arriving together with start arms the session for a single
      // FILL + DRAIN; a lone stop in IDLE is dropped.
      stop_pend_next = 1'b0;
      if (bus.start) begin
        state_next       = FILL;
        stop_pend_next   = bus.stop;
        gamma_start_next = 1'b1;
        net_sel_next     = 1'b1;
      end
    end else begin
      stop_pend_next   = stop_pend_reg | bus.stop;
      cnt_next         = wrap ? '0 : cnt_reg + 1'b1;
      half_next        = (half_reg == HALF_LAST) ? '0 : half_reg + 1'b1;
      wr_idx_next      = CW'({half_next, 1'b0});
      buf_sel_next     = buf_sel_reg ^ wrap;
      net_sel_next     = (cnt_next < CNT_HALF);
      gamma_start_next = (cnt_next == '0);

      if (wrap) begin
        unique case (state_reg)
          FILL:    state_next = stop_pend_reg ? DRAIN : RUN;
          RUN:     state_next = stop_pend_reg ? DRAIN : RUN;
          DRAIN: begin
            // End of session: drop back to the idle values, buffer select
            // included, so the next session starts on buffer 0.
            state_next       = IDLE;
            stop_pend_next   = 1'b0;
            cnt_next         = '0;
            half_next        = '0;
            wr_idx_next      = '0;
            buf_sel_next     = 1'b0;
            net_sel_next     = 1'b0;
            gamma_start_next = 1'b0;
          end
          default: state_next = IDLE;
        endcase
      end
    end

    busy_next = (state_next != IDLE);
  end

  assign bus.start_count        = busy_reg;
  assign bus.busy               = busy_reg;
  assign bus.cycle_counter      = cnt_reg;
  assign bus.half_cycle_counter = half_reg;
  assign bus.wr_idx             = wr_idx_reg;
  assign bus.buf_sel            = buf_sel_reg;
  assign bus.network_buf_sel    = net_sel_reg;
  assign bus.gamma_start        = gamma_start_reg;
  assign bus.out_valid          = out_valid_reg;
endmodule

// File: tb/tb_replay_schedule_ctrl.sv
// Directed bench for replay_schedule_ctrl with GAMMA_CYCLE_LENGTH = 18.
// A table of {inputs, edges to advance, expected outputs} walks one full
// session (FILL, RUN, stop, DRAIN, IDLE); hand-written sequences cover the
// start+stop-in-IDLE session and reset in the middle of RUN.
module tb_replay_schedule_ctrl;
  localparam int G = 18;

  logic clk;
  logic rstb;
  int   checks = 0;
  int   errors = 0;

  replay_schedule_if #(.GAMMA_CYCLE_LENGTH(G)) bus ();

  replay_schedule_ctrl #(.GAMMA_CYCLE_LENGTH(G)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  rstb;
    logic  start;
    logic  stop;
    int    edges;
    int    busy;
    int    ov;
    int    cnt;
    int    half;
    int    bsel;
    int    nsel;
    int    gs;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int busy, input int ov,
                         input int cnt, input int half, input int bsel,
                         input int nsel, input int gs);
    chk({name, ".busy"}, int'(bus.busy), busy);
    chk({name, ".start_count"}, int'(bus.start_count), busy);
    chk({name, ".out_valid"}, int'(bus.out_valid), ov);
    chk({name, ".cycle_counter"}, int'(bus.cycle_counter), cnt);
    chk({name, ".half_cycle_counter"}, int'(bus.half_cycle_counter), half);
    chk({name, ".wr_idx"}, int'(bus.wr_idx), 2 * half);
    chk({name, ".buf_sel"}, int'(bus.buf_sel), bsel);
    chk({name, ".network_buf_sel"}, int'(bus.network_buf_sel), nsel);
    chk({name, ".gamma_start"}, int'(bus.gamma_start), gs);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt, ov_cnt, gs_cnt;
    bit found;

    rstb      = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    //               name          rstb st sp edges busy ov cnt half bsel nsel gs
    vecs.push_back('{"reset",        0, 1, 1, 3,  0, 0,  0, 0, 0, 0, 0});
    vecs.push_back('{"idle_hold",    1, 0, 0, 2,  0, 0,  0, 0, 0, 0, 0});
    vecs.push_back('{"start_e0",     1, 1, 0, 1,  1, 0,  0, 0, 0, 1, 1});
    vecs.push_back('{"fill_e1",      1, 0, 0, 1,  1, 0,  1, 1, 0, 1, 0});
    vecs.push_back('{"fill_e17",     1, 0, 0, 16, 1, 0, 17, 8, 0, 0, 0});
    vecs.push_back('{"run_e18",      1, 0, 0, 1,  1, 0,  0, 0, 1, 1, 1});
    vecs.push_back('{"run_e19",      1, 0, 0, 1,  1, 1,  1, 1, 1, 1, 0});
    vecs.push_back('{"run_cnt8",     1, 0, 0, 7,  1, 1,  8, 8, 1, 1, 0});
    vecs.push_back('{"run_cnt9",     1, 0, 0, 1,  1, 1,  9, 0, 1, 0, 0});
    vecs.push_back('{"run_cnt17",    1, 0, 0, 8,  1, 1, 17, 8, 1, 0, 0});
    vecs.push_back('{"run_wrap",     1, 0, 0, 1,  1, 1,  0, 0, 0, 1, 1});
    vecs.push_back('{"run_start_ign",1, 1, 0, 5,  1, 1,  5, 5, 0, 1, 0});
    vecs.push_back('{"run_stop",     1, 0, 1, 1,  1, 1,  6, 6, 0, 1, 0});
    vecs.push_back('{"run_to_wrap",  1, 0, 0, 11, 1, 1, 17, 8, 0, 0, 0});
    vecs.push_back('{"drain_e0",     1, 0, 0, 1,  1, 1,  0, 0, 1, 1, 1});
    vecs.push_back('{"drain_e17",    1, 0, 0, 17, 1, 1, 17, 8, 1, 0, 0});
    vecs.push_back('{"idle_entry",   1, 0, 0, 1,  0, 1,  0, 0, 0, 0, 0});
    vecs.push_back('{"idle_ov_drop", 1, 0, 0, 1,  0, 0,  0, 0, 0, 0, 0});
    vecs.push_back('{"idle_stop_ign",1, 0, 1, 3,  0, 0,  0, 0, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      rstb      = vecs[i].rstb;
      bus.start = vecs[i].start;
      bus.stop  = vecs[i].stop;
      step(vecs[i].edges);
      chk_all(vecs[i].name, vecs[i].busy, vecs[i].ov, vecs[i].cnt,
              vecs[i].half, vecs[i].bsel, vecs[i].nsel, vecs[i].gs);
      $display("vector %0d %s: cnt=%0d half=%0d busy=%0d ov=%0d",
               i, vecs[i].name, bus.cycle_counter, bus.half_cycle_counter,
               bus.busy, bus.out_valid);
    end
    bus.stop = 1'b0;
    step(1);

    // start and stop together in IDLE: one FILL plus one DRAIN gamma cycle.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    busy_cnt = 0;
    ov_cnt   = 0;
    gs_cnt   = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) ov_cnt++;
      if (bus.gamma_start) gs_cnt++;
      if (i == 18) chk("startstop.buf_sel_mid", int'(bus.buf_sel), 1);
      step(1);
    end
    chk("startstop.busy_clks", busy_cnt, 36);
    chk("startstop.out_valid_clks", ov_cnt, 18);
    chk("startstop.gamma_pulses", gs_cnt, 2);
    chk("startstop.buf_sel_end", int'(bus.buf_sel), 0);
    chk("startstop.busy_end", int'(bus.busy), 0);
    $display("start+stop session: busy=%0d clks out_valid=%0d clks",
             busy_cnt, ov_cnt);

    // Reset in RUN at cnt=7 aborts immediately, then a clean restart.
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.out_valid && bus.cycle_counter == 7) found = 1'b1;
      else step(1);
    end
    chk("midreset.reach_run_cnt7", int'(found), 1);
    rstb = 1'b0;
    step(1);
    chk_all("midreset.abort", 0, 0, 0, 0, 0, 0, 0);
    rstb      = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    chk_all("midreset.restart", 1, 0, 0, 0, 0, 1, 1);
    step(18);
    chk_all("midreset.fill_done", 1, 0, 0, 0, 1, 1, 1);
    step(1);
    chk("midreset.run_ov", int'(bus.out_valid), 1);
    $display("mid-session reset and restart: cnt=%0d buf_sel=%0d",
             bus.cycle_counter, bus.buf_sel);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
